// File: rtl/mem_responder.sv
// mem_responder: data-memory responder for the multi-cycle RISC-V core.
// Accepts one load/store at a time, waits LATENCY cycles, then performs the
// access with byte/half/word lane handling and returns a one-cycle response.
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t              state;
  logic [3:0]          count;

  logic                we_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [1:0]          size_q;
  logic                signed_q;

  logic [31:0]         mem [2**ADDR_W];

  logic [ADDR_W-1:0]   word_idx;
  logic [1:0]          lane;
  logic                access_now;
  logic                accept;
  logic                misaligned;
  logic [3:0]          byte_en;
  logic [31:0]         store_data;
  logic [31:0]         load_data;
  logic [31:0]         rd_word;
  logic [15:0]         half_sel;
  logic [7:0]          byte_sel;
  logic                unused_addr_bits;

  // Upper address bits only alias the memory, so they are deliberately dropped.
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign word_idx   = addr_q[ADDR_W+1:2];
  assign lane       = addr_q[1:0];
  assign access_now = (state == WAIT) && (count == 4'd0);
  assign req_ready  = !rst && ((state == IDLE) || (state == RESP));
  assign accept     = req_valid && req_ready;

  // Decode the latched request into lane enables, replicated store data and extended load data.
  always_comb begin
    misaligned = 1'b0;
    byte_en    = 4'b0000;
    store_data = 32'd0;
    load_data  = 32'd0;
    rd_word    = mem[word_idx];
    half_sel   = 16'd0;
    byte_sel   = 8'd0;
    case (size_q)
      2'b00: begin
        misaligned = (lane != 2'b00);
        byte_en    = 4'b1111;
        store_data = wdata_q;
        load_data  = rd_word;
      end
      2'b01: begin
        misaligned = lane[0];
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata_q[15:0]}};
        half_sel   = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data  = {{16{signed_q & half_sel[15]}}, half_sel};
      end
      2'b10: begin
        byte_en    = 4'b0001 << lane;
        store_data = {4{wdata_q[7:0]}};
        byte_sel   = rd_word[8*lane +: 8];
        load_data  = {{24{signed_q & byte_sel[7]}}, byte_sel};
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  // Commit a store to the selected lanes when the wait period expires; errors and resets suppress it.
  always_ff @(posedge clk) begin
    if (!rst && access_now && we_q && !misaligned) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

  // Request/response sequencing: accept, count down the latency, then emit one registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        we_q     <= req_we;
        addr_q   <= req_addr[ADDR_W+1:0];
        wdata_q  <= req_wdata;
        size_q   <= req_size;
        signed_q <= req_signed;
        count    <= 4'(LATENCY - 1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= misaligned;
            rsp_rdata <= (misaligned || we_q) ? 32'd0 : load_data;
          end
        end
        RESP: begin
          state <= accept ? WAIT : IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus for mem_responder with a byte-array
// reference model and a per-cycle compare process on the falling edge.
module tb_mem_responder;

  localparam int ADDR_W    = 10;
  localparam int LATENCY   = 2;
  localparam int MEM_BYTES = 4 << ADDR_W;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    int          due;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
  } req_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          acc_count = 0;
  int          rsp_count = 0;
  int          acc_log[$];
  int          rsp_log[$];
  req_t        pending[$];
  logic        state_ready = 1'b1;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;
  logic [31:0] cap_rdata = 32'd0;
  logic        cap_err = 1'b0;
  logic [7:0]  bmem [0:MEM_BYTES-1];

  mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so response timing can be expressed in edges after acceptance
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: byte-addressed little-endian memory with aliasing
  function automatic void model_access(input req_t r, output logic [31:0] d, output logic e);
    int n;
    int a;
    n = (r.size == 2'd0) ? 4 : (r.size == 2'd1) ? 2 : 1;
    a = int'(r.addr) & (MEM_BYTES - 1);
    e = (r.size == 2'd3) || (a % n != 0);
    d = 32'd0;
    if (e) return;
    if (r.we) begin
      for (int i = 0; i < n; i++) bmem[a + i] = r.wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) d[8*i +: 8] = bmem[a + i];
      if (r.sgn && n < 4 && d[8*n-1]) d = d | ~((32'd1 << (8*n)) - 32'd1);
    end
  endfunction

  // Compare process: every falling edge, check handshake, strobe and held response data against the model
  always @(negedge clk) begin
    logic        exp_valid;
    logic [31:0] md;
    logic        me;
    if (rst) begin
      pending.delete();
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", {31'd0, rsp_err}, 32'd0);
      last_rdata  = 32'd0;
      last_err    = 1'b0;
      state_ready = 1'b1;
    end else begin
      if (req_valid && state_ready) begin
        pending.push_back('{due: cyc + LATENCY, we: req_we, addr: req_addr,
                            wdata: req_wdata, size: req_size, sgn: req_signed});
        acc_count++;
        acc_log.push_back(cyc);
      end
      exp_valid = (pending.size() > 0) && (pending[0].due == cyc);
      state_ready = (pending.size() == 0) || exp_valid;
      chk("req_ready", {31'd0, req_ready}, {31'd0, state_ready});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        model_access(pending[0], md, me);
        void'(pending.pop_front());
        chk("rsp_rdata", rsp_rdata, md);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, me});
        last_rdata = md;
        last_err   = me;
        cap_rdata  = rsp_rdata;
        cap_err    = rsp_err;
        rsp_count++;
        rsp_log.push_back(cyc);
      end else begin
        chk("hold_rdata", rsp_rdata, last_rdata);
        chk("hold_err", {31'd0, rsp_err}, {31'd0, last_err});
      end
    end
  end

  // Issue one request, wait (bounded) for its acceptance and its response
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic sgn);
    int n0;
    int r0;
    @(negedge clk); #1;
    n0 = acc_count;
    r0 = rsp_count;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_signed = sgn;
    for (int i = 0; i < 20 && acc_count == n0; i++) begin @(negedge clk); #1; end
    req_valid = 1'b0;
    chk("accept_timeout", acc_count, n0 + 1);
    for (int i = 0; i < 40 && rsp_count == r0; i++) begin @(negedge clk); #1; end
    chk("response_timeout", rsp_count, r0 + 1);
  endtask

  // Pin the most recent response to a hand-computed value
  task automatic checkOutput(input string name, input logic [31:0] exp_data, input logic exp_err);
    chk({name, "_data"}, cap_rdata, exp_data);
    chk({name, "_err"}, {31'd0, cap_err}, {31'd0, exp_err});
  endtask

  initial begin
    int n0;
    int r0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_size = 2'd0; req_signed = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Word store then load
    applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, 2'd0, 1'b0);
    checkOutput("sw_100", 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h100, 32'h0, 2'd0, 1'b0);
    checkOutput("lw_100", 32'hDEADBEEF, 1'b0);

    // Lane merge
    applyStimulus(1'b1, 32'h40, 32'h11223344, 2'd0, 1'b0);
    applyStimulus(1'b1, 32'h42, 32'h000000AA, 2'd2, 1'b0);
    applyStimulus(1'b1, 32'h40, 32'h0000BEEF, 2'd1, 1'b0);
    applyStimulus(1'b0, 32'h40, 32'h0, 2'd0, 1'b0);
    checkOutput("merge_40", 32'h11AABEEF, 1'b0);

    // Sign / zero extension
    applyStimulus(1'b1, 32'h8, 32'h00008080, 2'd0, 1'b0);
    applyStimulus(1'b0, 32'h8, 32'h0, 2'd2, 1'b1);
    checkOutput("lb_8", 32'hFFFFFF80, 1'b0);
    applyStimulus(1'b0, 32'h8, 32'h0, 2'd2, 1'b0);
    checkOutput("lbu_8", 32'h00000080, 1'b0);
    applyStimulus(1'b0, 32'h8, 32'h0, 2'd1, 1'b1);
    checkOutput("lh_8", 32'hFFFF8080, 1'b0);
    applyStimulus(1'b0, 32'h8, 32'h0, 2'd1, 1'b0);
    checkOutput("lhu_8", 32'h00008080, 1'b0);

    // Misalignment and illegal size
    applyStimulus(1'b1, 32'h102, 32'h12345678, 2'd0, 1'b0);
    checkOutput("sw_misaligned", 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h100, 32'h0, 2'd0, 1'b0);
    checkOutput("lw_after_err", 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 32'h101, 32'h0, 2'd1, 1'b1);
    checkOutput("lh_misaligned", 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd3, 1'b0);
    checkOutput("size_illegal", 32'h0, 1'b1);

    // Upper address bits alias onto the same word
    applyStimulus(1'b0, 32'h1100, 32'h0, 2'd0, 1'b0);
    checkOutput("lw_alias", 32'hDEADBEEF, 1'b0);

    // Back-to-back loads with req_valid held high
    @(negedge clk); #1;
    n0 = acc_count;
    r0 = rsp_count;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = 2'd0; req_signed = 1'b0;
    for (int i = 0; i < 40 && acc_count < n0 + 3; i++) begin @(negedge clk); #1; end
    req_valid = 1'b0;
    chk("b2b_accepts", acc_count, n0 + 3);
    for (int i = 0; i < 40 && rsp_count < r0 + 3; i++) begin @(negedge clk); #1; end
    chk("b2b_responses", rsp_count, r0 + 3);
    if (acc_count == n0 + 3 && rsp_count == r0 + 3) begin
      chk("b2b_gap1", acc_log[n0+1] - acc_log[n0], 3);
      chk("b2b_gap2", acc_log[n0+2] - acc_log[n0+1], 3);
      chk("b2b_lat", rsp_log[r0] - acc_log[n0], 2);
      chk("b2b_lat3", rsp_log[r0+2] - acc_log[n0+2], 2);
    end
    checkOutput("b2b_data", 32'hDEADBEEF, 1'b0);

    // Reset during the wait period of a store
    applyStimulus(1'b1, 32'h20, 32'h0, 2'd0, 1'b0);
    @(negedge clk); #1;
    n0 = acc_count;
    r0 = rsp_count;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_size = 2'd0;
    for (int i = 0; i < 20 && acc_count == n0; i++) begin @(negedge clk); #1; end
    req_valid = 1'b0;
    chk("rst_store_accept", acc_count, n0 + 1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("ready_in_rst", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    repeat (6) begin @(negedge clk); #1; end
    chk("no_rsp_after_rst", rsp_count, r0);
    applyStimulus(1'b0, 32'h20, 32'h0, 2'd0, 1'b0);
    checkOutput("lw_after_rst", 32'h00000000, 1'b0);

    repeat (4) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Data-memory responder for the multi-cycle RISC-V core. It accepts one load or store request at a time over a valid/ready handshake and applies byte, half or word lane masking on stores. It returns sign- or zero-extended load data after a fixed, parameterised latency and flags misaligned accesses. It sits on the memory side of the core's load/store path, opposite the core's address/byte-select/write-enable request logic.

## Interface
- `ADDR_W`, 10: word-address bits; storage depth is 2^ADDR_W 32-bit words.
- `LATENCY`, 2: number of WAIT cycles per access; legal range 1–15.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder can accept a request this cycle
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- `req_size`  in  2  00 word, 01 half, 10 byte, 11 illegal (same encoding as the core's byteSel)
- `req_signed`  in  1  1 = sign-extend load, 0 = zero-extend
- `rsp_valid`  out  1  one-cycle response strobe
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors
- `rsp_err`  out  1  misaligned or illegal-size request; valid with rsp_valid

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: counter runs.
  - RESP: rsp_valid=1 and req_ready=1.
- Acceptance: on a clk edge with req_valid & req_ready & !rst.
  - Latch we, addr, wdata, size and signed.
  - Load the counter with LATENCY-1.
  - Go to WAIT.
- WAIT with counter≠0: decrement. WAIT with counter=0: perform the access on the next edge and go to RESP.
- RESP lasts exactly one cycle.
  - A request accepted in RESP goes directly to WAIT, giving back-to-back operation.
  - Otherwise go to IDLE.
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so the memory aliases and wraps with no error.
- Little-endian lane selection:
  - byte lane = addr[1:0]
  - half lane = addr[1]
- Store behaviour:
  - Write only the selected lanes; other bytes of the word are unchanged.
  - Word writes all four bytes.
- Load behaviour:
  - Extract the lane and extend to 32 bits per req_signed.
  - Word loads ignore req_signed.
- Error conditions:
  - half with addr[0]=1
  - word with addr[1:0]≠0
  - size=11
- On error: no memory write, rsp_err=1, rsp_rdata=0.
- Memory contents are not affected by rst and are undefined at power-up.

## Timing
- Reset values (while rst=1 and on the cycle after): state IDLE, counter 0, req_ready=0 while rst=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset mid-operation (WAIT or RESP): the request is abandoned. A pending store is NOT written, and no rsp_valid follows.
- Request accepted at edge E0:
  - Memory read/write occurs at edge E0+LATENCY.
  - rsp_valid is high for the cycle after E0+LATENCY, then low.
- Throughput: one request per LATENCY+1 cycles when requests are held valid continuously.
- rsp_rdata and rsp_err are registered. They hold their values after rsp_valid drops until the next response.
- Reads observe all previously responded stores; there are no hazards because only one request is outstanding.
- Request inputs are don't-care when not accepted. Holding req_valid high in WAIT has no effect.

## Test plan
- Word store/load: sw 0xDEADBEEF @0x100, then lw @0x100 → rsp_rdata=0xDEADBEEF, rsp_err=0.
- Lane merge: after sw 0x11223344 @0x40, sb 0xAA @0x42, sh 0xBEEF @0x40 → lw @0x40 returns 0x11AABEEF.
- Extension: word 0x00008080 @0x8.
  - lb @0x8 → 0xFFFFFF80; lbu @0x8 → 0x00000080.
  - lh @0x8 → 0xFFFF8080; lhu @0x8 → 0x00008080.
- Misalignment:
  - sw 0x12345678 @0x102 → rsp_err=1, rsp_rdata=0; a following lw @0x100 returns the prior contents unchanged.
  - lh @0x101 → rsp_err=1.
  - size=11 → rsp_err=1.
- Latency and back-to-back, with LATENCY=2 and req_valid held high for 3 loads:
  - rsp_valid pulses 2 edges after each acceptance.
  - Acceptances occur in the RESP cycles, one every 3 cycles.
- Reset mid-store: sw 0xCAFEF00D @0x20 over prior content 0x0; assert rst for 1 cycle during WAIT.
  - No rsp_valid is produced.
  - req_ready=0 during rst.
  - lw @0x20 afterwards → 0x00000000.
